// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick between the fetch and data requesters.
// Build option ARB_ROUND_ROBIN_EN: prio_i is the round-robin pointer;
// otherwise prio_i is the starvation-force flag and data normally wins.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic prio_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    // Choose the requester to be granted this cycle.
    always_comb begin
        grant_valid_o = if_req_i | d_req_i;
        grant_id_o    = REQ_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req_i && d_req_i) begin
            grant_id_o = prio_i;
        end else if (d_req_i) begin
            grant_id_o = REQ_D;
        end
`else
        // Fetch only beats data when it has been starved long enough.
        if (d_req_i && !(if_req_i && prio_i)) begin
            grant_id_o = REQ_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store
// port. Transactions are serialised IDLE -> GRANT -> RESP; all outputs are
// registered. Build option ARB_ROUND_ROBIN_EN swaps the data-first policy
// with its fetch starvation guard for a 1-bit round-robin pointer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);

    arb_state_t        state_q;
    req_id_t           owner_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q;

    logic              prio;
    logic              grant_valid;
    logic              grant_id_raw;
    req_id_t           grant_id;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t rr_ptr_q;

    assign prio = rr_ptr_q;
`else
    localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CntW-1:0] starve_cnt_q;

    // A saturated counter forces the pending fetch through; MAX_WAIT=0 never forces.
    assign prio = (MAX_WAIT != 0) && (starve_cnt_q == CntW'(MAX_WAIT));
`endif

    assign grant_id = req_id_t'(grant_id_raw);

    mem_arb_select u_select (
        .if_req_i      (if_req_i),
        .d_req_i       (d_req_i),
        .prio_i        (prio),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id_raw)
    );

    // Transaction FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            owner_q     <= REQ_IF;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= REQ_IF;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q   <= GRANT;
                        owner_q   <= grant_id;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        if (grant_id == REQ_D) begin
                            mem_we_q    <= d_we_i;
                            mem_addr_q  <= d_addr_i;
                            mem_wdata_q <= d_wdata_i;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr_i;
                            mem_wdata_q <= '0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr_q <= (grant_id == REQ_IF) ? REQ_D : REQ_IF;
`else
                        // Count data wins only while a fetch is left waiting.
                        if (grant_id == REQ_D && if_req_i) begin
                            if (starve_cnt_q != CntW'(MAX_WAIT)) begin
                                starve_cnt_q <= starve_cnt_q + 1'b1;
                            end
                        end else begin
                            starve_cnt_q <= '0;
                        end
`endif
                    end
                end
                GRANT: begin
                    if (mem_ack_i) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (owner_q == REQ_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata_i;
                        end else begin
                            d_ack_q <= 1'b1;
                            // Stores leave the last load value in place.
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata_i;
                            end
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed requester stimulus, a
// small memory with configurable ack delay, and a transaction-level model
// compared against the DUT every cycle. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_ack_o    (if_ack),
        .if_rdata_o  (if_rdata),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_ack_o     (d_ack),
        .d_rdata_o   (d_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .busy_o      (busy)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: 256 words, acks after mem_stall wait cycles, optional spurious acks.
    logic [31:0] mem [0:255];
    int mem_stall = 0;
    int wcnt = 0;
    bit spur = 1'b0;

    // Model state (1 = data requester).
    bit          m_tx, m_acking, m_owner_d, m_we, m_pref;
    int          m_starve;
    logic        exp_mem_req, exp_mem_we, exp_if_ack, exp_d_ack, exp_busy;
    logic [31:0] exp_mem_addr, exp_mem_wdata, exp_if_rdata, exp_d_rdata;
    bit          model_log[$];
    bit          dut_log[$];
    logic        prev_mem_req = 1'b0;

    initial begin
        m_tx = 0; m_acking = 0; m_owner_d = 0; m_we = 0; m_pref = 0; m_starve = 0;
        exp_mem_req = 0; exp_mem_we = 0; exp_if_ack = 0; exp_d_ack = 0; exp_busy = 0;
        exp_mem_addr = 0; exp_mem_wdata = 0; exp_if_rdata = 0; exp_d_rdata = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
    end

    // Compare, drive the memory, then advance the model for the next edge.
    always @(negedge clk) begin
        bit win_d;
        if (chk_en) begin
            chk("mem_req", mem_req, exp_mem_req);
            chk("mem_we", mem_we, exp_mem_we);
            chk("if_ack", if_ack, exp_if_ack);
            chk("d_ack", d_ack, exp_d_ack);
            chk("busy", busy, exp_busy);
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("d_rdata", d_rdata, exp_d_rdata);
            if (exp_mem_req) chk("mem_addr", mem_addr, exp_mem_addr);
            if (exp_mem_req && exp_mem_we) chk("mem_wdata", mem_wdata, exp_mem_wdata);
            if (mem_req === 1'b1 && prev_mem_req !== 1'b1)
                dut_log.push_back(!(mem_addr == if_addr && mem_we == 1'b0));
        end
        prev_mem_req = mem_req;

        if (mem_req === 1'b1) begin
            if (wcnt >= mem_stall) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we === 1'b1) mem[mem_addr[9:2]] = mem_wdata;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            wcnt = 0;
            mem_ack = spur;
            mem_rdata = spur ? 32'hBAD0_BAD0 : 32'h0;
        end

        if (reset === 1'b1) begin
            m_tx = 0; m_acking = 0; m_pref = 0; m_starve = 0;
            exp_mem_req = 0; exp_mem_we = 0; exp_if_ack = 0; exp_d_ack = 0; exp_busy = 0;
            exp_mem_addr = 0; exp_mem_wdata = 0; exp_if_rdata = 0; exp_d_rdata = 0;
        end else if (m_acking) begin
            m_acking = 0;
            exp_if_ack = 0;
            exp_d_ack = 0;
            exp_busy = 0;
        end else if (m_tx) begin
            if (mem_ack) begin
                m_tx = 0;
                m_acking = 1;
                exp_mem_req = 0;
                exp_mem_we = 0;
                if (m_owner_d) begin
                    exp_d_ack = 1;
                    if (!m_we) exp_d_rdata = mem_rdata;
                end else begin
                    exp_if_ack = 1;
                    exp_if_rdata = mem_rdata;
                end
            end
        end else if (if_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (if_req && d_req) win_d = m_pref;
            else win_d = d_req;
            m_pref = !win_d;
`else
            if (if_req && d_req && MW != 0 && m_starve >= int'(MW)) win_d = 0;
            else win_d = d_req;
            if (win_d && if_req) m_starve = (m_starve < int'(MW)) ? m_starve + 1 : int'(MW);
            else m_starve = 0;
`endif
            model_log.push_back(win_d);
            m_tx = 1;
            m_owner_d = win_d;
            m_we = win_d && d_we;
            exp_mem_req = 1;
            exp_mem_we = m_we;
            exp_mem_addr = win_d ? d_addr : if_addr;
            exp_mem_wdata = d_wdata;
            exp_busy = 1;
        end
    end

    // Requester agents: drop a request the cycle after its ack unless held.
    int cyc = 0;
    int n_if_ack = 0, n_d_ack = 0, if_ack_cyc = -1, d_ack_cyc = -1;
    bit if_hold = 0, d_hold = 0, if_drop = 0, d_drop = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (if_drop) begin if_req = 1'b0; if_drop = 1'b0; end
        if (d_drop) begin d_req = 1'b0; d_drop = 1'b0; end
        if (if_ack === 1'b1) begin
            n_if_ack++; if_ack_cyc = cyc;
            if (!if_hold) if_drop = 1'b1;
        end
        if (d_ack === 1'b1) begin
            n_d_ack++; d_ack_cyc = cyc;
            if (!d_hold) d_drop = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!if_req && !d_req && busy === 1'b0 && !if_drop && !d_drop) break;
            step();
        end
        chk("idle_reached", (i < budget), 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; if_drop = 0; d_drop = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [5:0] pack6(input bit q[$]);
        logic [5:0] v = '0;
        for (int i = 0; i < 6; i++) v = {v[4:0], (i < q.size()) ? q[i] : 1'b0};
        return v;
    endfunction

    initial begin
        logic [5:0] exp_order;
        int n_if0, n_d0;

        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i * 4);
        mem[4]  = 32'hE3A0_0001;
        mem[32] = 32'h1234_5678;
        mem[33] = 32'hCAFE_0084;

        reset = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b0;
        step();

        // Lone fetch, same-cycle memory ack.
        cyc = 0; if_addr = 32'h10; if_req = 1'b1;
        step();
        chk("lone_mem_req_c1", mem_req, 1);
        chk("lone_mem_addr_c1", mem_addr, 32'h10);
        step();
        chk("lone_if_ack_c2", if_ack, 1);
        chk("lone_if_rdata_c2", if_rdata, 32'hE3A0_0001);
        step();
        chk("lone_busy_c3", busy, 0);
        wait_idle(10);

        // Simultaneous fetch and load.
        cyc = 0; if_ack_cyc = -1; d_ack_cyc = -1;
        n_if0 = n_if_ack; n_d0 = n_d_ack;
        if_addr = 32'h20; d_addr = 32'h80; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 20 && !(n_if_ack > n_if0 && n_d_ack > n_d0); i++) step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("simul_if_ack_cyc", if_ack_cyc, 2);
        chk("simul_d_ack_cyc", d_ack_cyc, 5);
`else
        chk("simul_d_ack_cyc", d_ack_cyc, 2);
        chk("simul_if_ack_cyc", if_ack_cyc, 5);
`endif
        chk("simul_d_rdata", d_rdata, 32'h1234_5678);
        chk("simul_if_rdata", if_rdata, 32'hA5A5_0020);
        wait_idle(10);

        // Continuous contention: starvation guard or round-robin order.
        pulse_reset();
        dut_log.delete();
        model_log.delete();
        if_addr = 32'h30; d_addr = 32'h84; d_we = 1'b0;
        if_hold = 1; d_hold = 1; if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 80 && dut_log.size() < 6; i++) step();
        if_hold = 0; d_hold = 0;
        wait_idle(40);
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 6'b010101;
`else
        exp_order = 6'b110110;
`endif
        chk("grant_order_dut", pack6(dut_log), exp_order);
        chk("grant_order_model", pack6(model_log), exp_order);
        chk("starve_if_rdata", if_rdata, 32'hA5A5_0030);
        chk("starve_d_rdata", d_rdata, 32'hCAFE_0084);

        // Store held stable through 3 stall cycles.
        mem_stall = 3;
        cyc = 0; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'h7; d_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("st_mem_req", mem_req, 1);
            chk("st_mem_we", mem_we, 1);
            chk("st_mem_addr", mem_addr, 32'h64);
            chk("st_mem_wdata", mem_wdata, 32'h7);
            chk("st_no_early_ack", d_ack, 0);
        end
        step();
        chk("st_d_ack_c5", d_ack, 1);
        chk("st_d_rdata_kept", d_rdata, 32'hCAFE_0084);
        wait_idle(10);
        mem_stall = 0;
        cyc = 0; d_we = 1'b0; d_req = 1'b1; d_ack_cyc = -1;
        for (int i = 0; i < 20 && d_ack_cyc < 0; i++) step();
        chk("ld_back_lat", d_ack_cyc, 2);
        chk("ld_back_rdata", d_rdata, 32'h7);
        wait_idle(10);

        // Spurious memory acks while idle are ignored.
        n_if0 = n_if_ack; n_d0 = n_d_ack;
        spur = 1'b1;
        step(); step(); step();
        spur = 1'b0;
        step();
        chk("spur_if_acks", n_if_ack, n_if0);
        chk("spur_d_acks", n_d_ack, n_d0);
        chk("spur_busy", busy, 0);

        // Reset while the memory access is outstanding.
        mem_stall = 10;
        n_if0 = n_if_ack; n_d0 = n_d_ack;
        cyc = 0; if_addr = 32'h10; if_req = 1'b1;
        step();
        chk("rg_mem_req_c1", mem_req, 1);
        reset = 1'b1;
        step();
        chk("rg_mem_req_after", mem_req, 0);
        chk("rg_busy_after", busy, 0);
        reset = 1'b0; if_req = 1'b0; if_drop = 0; d_drop = 0;
        for (int i = 0; i < 4; i++) step();
        chk("rg_no_if_ack", n_if_ack, n_if0);
        chk("rg_no_d_ack", n_d_ack, n_d0);
        mem_stall = 0;
        cyc = 0; if_ack_cyc = -1; if_addr = 32'h20; if_req = 1'b1;
        for (int i = 0; i < 20 && if_ack_cyc < 0; i++) step();
        chk("rg_fresh_lat", if_ack_cyc, 2);
        chk("rg_fresh_rdata", if_rdata, 32'hA5A5_0020);
        wait_idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU's instruction-fetch port and its load/store data port.
- Sits between the CPU top (fetch side and data side) and the memory model.
- Serialises accesses through a request/ack FSM, arbitrates simultaneous requests, and guards fetch against starvation.
- Enables the move from split Harvard memories to a single shared memory.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced to win; 0 disables the guard.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  DATA_W  fetched word; valid when if_ack is high.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DATA_W  load data; valid when d_ack is high.
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; may assert in the same cycle mem_req first rises.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: all outputs 0, state=IDLE, starvation counter=0, rr pointer=instruction.
- States and transitions:
  - IDLE: if any request is pending, pick a winner, latch owner/we/addr/wdata, go to GRANT. Otherwise stay.
  - GRANT: mem_req=1 and mem_* are driven from the latched copy, held stable until mem_ack. On mem_ack: latch mem_rdata into the owner's rdata register, go to RESP.
  - RESP: owner's ack=1 for exactly this cycle; mem_req=0; go to IDLE.
- The requester deasserts req (or presents a new request) from the cycle after ack. IDLE evaluates requests one cycle after RESP, so a duplicate grant is impossible.
- Latency: request seen in IDLE at cycle 0 → mem_req at cycle 1 → ack at cycle 2 (with mem_ack at cycle 1). Minimum 3 cycles per transaction; each extra mem_ack wait adds 1 cycle.
- Arbitration (default, fixed priority): data beats fetch.
- Starvation guard:
  - Counter increments on every data grant while if_req is also high.
  - Counter clears on any fetch grant, or on a data grant with if_req low.
  - When counter==MAX_WAIT and both requests are pending, fetch wins.
  - Counter saturates at MAX_WAIT.
- rdata registers hold their last value between acks. Stores leave d_rdata unchanged.
- Requests arriving during GRANT/RESP wait; nothing is queued beyond req being held high.
- Requester drops req before ack: protocol violation, not supported; the latched transaction still completes.
- Reset mid-transaction: the next edge forces IDLE with all outputs 0. The in-flight memory access is abandoned and no ack is issued.
- mem_ack outside GRANT: ignored.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin replaces fixed priority.
  - A 1-bit pointer names the preferred requester and flips to the other requester after each grant.
  - The starvation counter is absent (MAX_WAIT ignored).
- Undefined: fixed data-first priority with the MAX_WAIT guard as described above.

Decomposition:
- Package mem_arb_pkg:
  - Typedef arb_state_t: IDLE, GRANT, RESP.
  - Typedef req_id_t (1 bit), with constants REQ_IF=0, REQ_D=1.
- Sub-module mem_arb_select: combinational winner pick.
  - Inputs: if_req, d_req, starvation-force flag or rr pointer.
  - Outputs: grant_valid, grant_id.
- The FSM, counters and data registers stay in mem_port_arbiter.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10, memory acks in the same cycle with 0xE3A00001 → mem_req at cycle 1, if_ack at cycle 2 with if_rdata=0xE3A00001, busy low at cycle 3.
- Simultaneous: if_req and d_req (load 0x80) both rise in IDLE → data is granted first and d_ack precedes if_ack; fetch then completes 3 cycles later.
- Starvation, MAX_WAIT=2: if_req held high while d_req is re-asserted continuously → grant order D, D, IF, D, D, IF.
- Store with wait: d_we=1, d_addr=0x64, d_wdata=0x7 → mem_we=1, mem_addr=0x64, mem_wdata=0x7 held stable through 3 stall cycles; d_ack 1 cycle after mem_ack; d_rdata unchanged.
- Reset in GRANT: assert reset while mem_req=1 → mem_req=0 next cycle, no ack ever issued, state IDLE; a fresh fetch then works normally.
- ARB_ROUND_ROBIN_EN: both requests held continuously → grants alternate IF, D, IF, D, starting with IF after reset.
